// File: rtl/dma_req_encoder.sv
// Round-robin arbiter for io1/io2/mem DMA requests: offers a 3-bit region code with valid/ack, then holds a one-hot grant.
// One cycle from request to offer and from ack to grant. The grant is held until xfer_done, or for at most HOLD_MAX cycles.
module dma_req_encoder #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io1_req,
  input  logic       io2_req,
  input  logic       mem_req,
  input  logic       code_ack,
  input  logic       xfer_done,
  output logic [2:0] code,
  output logic       code_valid,
  output logic       io1_gnt,
  output logic       io2_gnt,
  output logic       mem_gnt,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY} state_t;

  // Source index: 0 = io1, 1 = io2, 2 = mem. The index is also the region code.
  state_t          r_state, w_state_nxt;
  logic [1:0]      r_win, w_win_nxt;
  logic [1:0]      r_last, w_last_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_code, w_code_nxt;
  logic            r_code_valid, w_code_valid_nxt;
  logic [2:0]      r_gnt, w_gnt_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic [2:0]      w_req;
  logic [1:0]      w_pick;
  logic            w_win_req;

  assign w_req     = {mem_req, io2_req, io1_req};
  assign w_win_req = w_req[r_win];

  // Search starts at the source after the last one that completed a grant.
  always_comb begin
    w_pick = 2'd0;
    unique case (r_last)
      2'd0: begin
        if (w_req[1])      w_pick = 2'd1;
        else if (w_req[2]) w_pick = 2'd2;
        else               w_pick = 2'd0;
      end
      2'd1: begin
        if (w_req[2])      w_pick = 2'd2;
        else if (w_req[0]) w_pick = 2'd0;
        else               w_pick = 2'd1;
      end
      default: begin
        if (w_req[0])      w_pick = 2'd0;
        else if (w_req[1]) w_pick = 2'd1;
        else               w_pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_win_nxt        = r_win;
    w_last_nxt       = r_last;
    w_cnt_nxt        = r_cnt;
    w_code_nxt       = r_code;
    w_code_valid_nxt = r_code_valid;
    w_gnt_nxt        = r_gnt;
    w_timeout_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_code_valid_nxt = 1'b0;
        w_gnt_nxt        = 3'b000;
        if (|w_req) begin
          w_win_nxt        = w_pick;
          w_code_nxt       = {1'b0, w_pick};
          w_code_valid_nxt = 1'b1;
          w_state_nxt      = S_OFFER;
        end
      end
      S_OFFER: begin
        // A withdrawn request cancels the offer even if ack arrives that same cycle.
        if (!w_win_req) begin
          w_code_valid_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end else if (code_ack) begin
          w_code_valid_nxt = 1'b0;
          w_gnt_nxt        = 3'b001 << r_win;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (xfer_done) begin
          w_gnt_nxt   = 3'b000;
          w_last_nxt  = r_win;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(HOLD_MAX - 1)) begin
          w_gnt_nxt     = 3'b000;
          w_timeout_nxt = 1'b1;
          w_last_nxt    = r_win;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_win        <= 2'd0;
      r_last       <= 2'd2;
      r_cnt        <= '0;
      r_code       <= 3'b000;
      r_code_valid <= 1'b0;
      r_gnt        <= 3'b000;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_win        <= w_win_nxt;
      r_last       <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_code       <= w_code_nxt;
      r_code_valid <= w_code_valid_nxt;
      r_gnt        <= w_gnt_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign io1_gnt    = r_gnt[0];
  assign io2_gnt    = r_gnt[1];
  assign mem_gnt    = r_gnt[2];
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_dma_req_encoder.sv
// Bench for dma_req_encoder: directed scenarios plus randomized transactions checked
// against a transaction-level round-robin model.
module tb_dma_req_encoder;

  localparam int HOLD = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       io1_req, io2_req, mem_req, code_ack, xfer_done;
  logic [2:0] code;
  logic       code_valid, io1_gnt, io2_gnt, mem_gnt, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_req_encoder #(.HOLD_MAX(HOLD), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .io1_req(io1_req), .io2_req(io2_req), .mem_req(mem_req),
    .code_ack(code_ack), .xfer_done(xfer_done),
    .code(code), .code_valid(code_valid),
    .io1_gnt(io1_gnt), .io2_gnt(io2_gnt), .mem_gnt(mem_gnt),
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] gnt_vec();
    return {mem_gnt, io2_gnt, io1_gnt};
  endfunction

  task automatic set_req(input logic [2:0] r);
    {mem_req, io2_req, io1_req} = r;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_req(3'b000); code_ack = 1'b0; xfer_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_offer(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (code_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s: code_valid did not rise within 10 cycles", tag);
    end
  endtask

  // Reference: next winner is the first requester after 'last' in io1->io2->mem order.
  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; set_req(3'b111); code_ack = 1'b1; xfer_done = 1'b1;
    tick(); tick();
    n_checks++;
    if ({code, code_valid, gnt_vec(), timeout} !== 8'b000_0_000_0) begin
      n_fail++;
      $display("FAIL reset_outputs: got code=%b cv=%b gnt=%b to=%b, expected all zero",
               code, code_valid, gnt_vec(), timeout);
    end
    rst = 1'b0; set_req(3'b000); code_ack = 1'b0; xfer_done = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    io1_req = 1'b1;                       // cycle 0
    tick();                               // cycle 1
    n_checks++;
    if (code_valid !== 1'b1 || code !== 3'b000) begin
      n_fail++; $display("FAIL basic_offer: got cv=%b code=%b expected 1/000", code_valid, code);
    end
    tick();                               // cycle 2
    code_ack = 1'b1;
    tick();                               // cycle 3
    code_ack = 1'b0;
    n_checks++;
    if (gnt_vec() !== 3'b001 || code_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_grant: got gnt=%b cv=%b expected 001/0", gnt_vec(), code_valid);
    end
    tick();                               // cycle 4
    tick();                               // cycle 5
    xfer_done = 1'b1;
    tick();                               // cycle 6
    xfer_done = 1'b0;
    n_checks++;
    if (gnt_vec() !== 3'b000) begin
      n_fail++; $display("FAIL basic_release: got gnt=%b expected 000", gnt_vec());
    end
    io1_req = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_rr[4] = '{0, 1, 2, 0};
    bit ok;
    logic [2:0] e;
    do_reset();
    set_req(3'b111);
    for (int i = 0; i < 4; i++) begin
      wait_offer("rr_offer", ok);
      n_checks++;
      if (code !== 3'(exp_rr[i])) begin
        n_fail++; $display("FAIL rr_code[%0d]: got %b expected %0d", i, code, exp_rr[i]);
      end
      tick();
      code_ack = 1'b1;
      tick();
      code_ack = 1'b0;
      e = 3'b001 << exp_rr[i];
      n_checks++;
      if (gnt_vec() !== e) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_vec(), e);
      end
      tick();
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
    end
    set_req(3'b000);
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    do_reset();
    set_req(3'b010);
    wait_offer("to_offer", ok);
    n_checks++;
    if (code !== 3'b001) begin
      n_fail++; $display("FAIL to_code: got %b expected 001", code);
    end
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && io2_gnt === 1'b1; i++) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != HOLD) begin
      n_fail++; $display("FAIL to_hold_len: got %0d cycles expected %0d", cnt, HOLD);
    end
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++; $display("FAIL to_pulse: got timeout=%b expected 1 as grant falls", timeout);
    end
    set_req(3'b111);
    tick();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse_len: got timeout=%b expected 0 one cycle later", timeout);
    end
    wait_offer("to_next", ok);
    n_checks++;
    if (code !== 3'b010) begin
      n_fail++; $display("FAIL to_next_code: got %b expected 010", code);
    end
    set_req(3'b000);
  endtask

  task automatic test_offer_drop();
    bit ok;
    do_reset();
    set_req(3'b100);
    wait_offer("drop_offer", ok);
    mem_req  = 1'b0;
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    n_checks++;
    if (code_valid !== 1'b0 || mem_gnt !== 1'b0) begin
      n_fail++; $display("FAIL drop_cancel: got cv=%b mem_gnt=%b expected 0/0", code_valid, mem_gnt);
    end
    tick();
    n_checks++;
    if (gnt_vec() !== 3'b000) begin
      n_fail++; $display("FAIL drop_nogrant: got gnt=%b expected 000", gnt_vec());
    end
    io1_req = 1'b1;
    wait_offer("drop_next", ok);
    n_checks++;
    if (code !== 3'b000) begin
      n_fail++; $display("FAIL drop_next_code: got %b expected 000", code);
    end
    set_req(3'b000);
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    do_reset();
    set_req(3'b010);
    wait_offer("rst_offer", ok);
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    set_req(3'b011);
    tick();
    n_checks++;
    if ({code, code_valid, gnt_vec(), timeout} !== 8'b000_0_000_0) begin
      n_fail++;
      $display("FAIL rst_busy: got code=%b cv=%b gnt=%b to=%b expected all zero",
               code, code_valid, gnt_vec(), timeout);
    end
    rst = 1'b0;
    wait_offer("rst_next", ok);
    n_checks++;
    if (code !== 3'b000) begin
      n_fail++; $display("FAIL rst_next_code: got %b expected 000", code);
    end
    set_req(3'b000);
  endtask

  task automatic test_done_at_expiry();
    bit ok;
    do_reset();
    set_req(3'b001);
    wait_offer("exp_offer", ok);
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    for (int k = 1; k < HOLD; k++) tick();
    n_checks++;
    if (io1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL exp_last_cycle: got io1_gnt=%b expected 1", io1_gnt);
    end
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    n_checks++;
    if (gnt_vec() !== 3'b000 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL exp_done_wins: got gnt=%b to=%b expected 000/0", gnt_vec(), timeout);
    end
    set_req(3'b000);
  endtask

  task automatic test_random();
    int last;
    int w, dpos, cnt, exp_cnt, dly;
    bit ok, exp_to;
    logic [2:0] r, e;
    do_reset();
    last = 2;
    for (int it = 0; it < 40; it++) begin
      r = 3'($urandom_range(1, 7));
      set_req(r);
      wait_offer("rand_offer", ok);
      if (!ok) begin
        do_reset(); last = 2;
        continue;
      end
      w = rr_pick(last, r);
      n_checks++;
      if (code !== 3'(w)) begin
        n_fail++; $display("FAIL rand_code[%0d]: got %b expected %0d req=%b", it, code, w, r);
      end
      if ($urandom_range(0, 4) == 0) begin
        r[w] = 1'b0;
        set_req(r);
        tick();
        n_checks++;
        if (code_valid !== 1'b0 || gnt_vec() !== 3'b000) begin
          n_fail++; $display("FAIL rand_drop[%0d]: got cv=%b gnt=%b expected 0/000", it, code_valid, gnt_vec());
        end
      end else begin
        dly = $urandom_range(0, 2);
        for (int d = 0; d < dly; d++) begin
          tick();
          n_checks++;
          if (code_valid !== 1'b1 || code !== 3'(w)) begin
            n_fail++; $display("FAIL rand_hold[%0d]: got cv=%b code=%b expected 1/%0d", it, code_valid, code, w);
          end
        end
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
        e = 3'b001 << w;
        dpos = $urandom_range(1, 18);
        cnt = 0;
        for (int i = 0; i < 25 && gnt_vec() === e; i++) begin
          cnt++;
          if (cnt == dpos) xfer_done = 1'b1;
          tick();
          xfer_done = 1'b0;
        end
        exp_cnt = (dpos <= HOLD) ? dpos : HOLD;
        exp_to  = (dpos > HOLD);
        n_checks++;
        if (cnt != exp_cnt || timeout !== exp_to || gnt_vec() !== 3'b000) begin
          n_fail++;
          $display("FAIL rand_grant[%0d]: got len=%0d to=%b gnt=%b expected len=%0d to=%b gnt=000",
                   it, cnt, timeout, gnt_vec(), exp_cnt, exp_to);
        end
        last = w;
      end
      set_req(3'b000);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; set_req(3'b000); code_ack = 1'b0; xfer_done = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_offer_drop();
    test_reset_mid_busy();
    test_done_at_expiry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
